// File: rtl/mcdt_pkt_formatter_if.sv
// Packet output stream of mcdt_pkt_formatter: valid/ready handshake with
// start-of-packet (header) and end-of-packet (last payload) markers.
interface mcdt_pkt_formatter_if;
  logic [31:0] fmt_data_o;
  logic        fmt_valid_o;
  logic        fmt_ready_i;
  logic        fmt_sop_o;
  logic        fmt_eop_o;

  modport master (output fmt_data_o, fmt_valid_o, fmt_sop_o, fmt_eop_o, input fmt_ready_i);
  modport slave  (input fmt_data_o, fmt_valid_o, fmt_sop_o, fmt_eop_o, output fmt_ready_i);
endinterface

// File: rtl/mcdt_pkt_formatter.sv
// Sorts the mcdt word stream into per-channel FIFOs and emits fixed-length
// packets (one header + PKT_LEN payload words) round-robin over a valid/ready stream.
module mcdt_pkt_formatter #(
  parameter int unsigned PKT_LEN = 4,
  parameter logic [7:0]  HDR_TAG = 8'hA5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [31:0]                 mcdt_data_i,
  input  logic                        mcdt_val_i,
  input  logic [1:0]                  mcdt_id_i,
  mcdt_pkt_formatter_if.master        fmt,
  output logic [2:0]                  ovf_o,
  input  logic                        clr_ovf_i
);
  localparam int unsigned DEPTH = 2 * PKT_LEN;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAY = 2'd2} state_t;

  logic [31:0] mem_q [3][DEPTH];
  ptr_t        wr_ptr_q [3];
  ptr_t        rd_ptr_q [3];
  cnt_t        cnt_q [3];
  logic [2:0]  ovf_q;
  logic [7:0]  seq_q [3];
  state_t      state_q;
  logic [1:0]  ch_q;
  logic [1:0]  rr_q;
  logic [3:0]  idx_q;
  logic [31:0] data_q;
  logic        valid_q;
  logic        sop_q;
  logic        eop_q;

  logic [2:0]  wr_s;
  logic [2:0]  pop_s;
  logic [2:0]  acc_s;
  logic [2:0]  set_s;
  logic [2:0]  elig_s;
  logic        gnt_ok_s;
  logic [1:0]  gnt_ch_s;
  logic [1:0]  cand_s;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  function automatic logic [1:0] ch_wrap(input logic [2:0] s);
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Per-channel write/pop qualification; a full FIFO that pops this cycle still accepts
  always_comb begin
    wr_s   = 3'b000;
    pop_s  = 3'b000;
    acc_s  = 3'b000;
    set_s  = 3'b000;
    elig_s = 3'b000;
    for (int c = 0; c < 3; c++) begin
      wr_s[c]   = mcdt_val_i && (mcdt_id_i == 2'(c));
      pop_s[c]  = (state_q == PAY) && fmt.fmt_ready_i && (ch_q == 2'(c));
      acc_s[c]  = wr_s[c] && ((cnt_q[c] != cnt_t'(DEPTH)) || pop_s[c]);
      set_s[c]  = wr_s[c] && !acc_s[c];
      elig_s[c] = cnt_q[c] >= cnt_t'(PKT_LEN);
    end
  end

  // Round-robin pick: scanning offsets high to low lets the nearest eligible channel win
  always_comb begin
    gnt_ok_s = 1'b0;
    gnt_ch_s = rr_q;
    cand_s   = rr_q;
    for (int k = 2; k >= 0; k--) begin
      cand_s   = ch_wrap({1'b0, rr_q} + 3'(k));
      gnt_ok_s = gnt_ok_s | elig_s[cand_s];
      gnt_ch_s = elig_s[cand_s] ? cand_s : gnt_ch_s;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flags (set beats clear)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < 3; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      ovf_q <= 3'b000;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (acc_s[c]) wr_ptr_q[c] <= ptr_inc(wr_ptr_q[c]);
        if (pop_s[c]) rd_ptr_q[c] <= ptr_inc(rd_ptr_q[c]);
        case ({acc_s[c], pop_s[c]})
          2'b10:   cnt_q[c] <= cnt_q[c] + cnt_t'(1);
          2'b01:   cnt_q[c] <= cnt_q[c] - cnt_t'(1);
          default: cnt_q[c] <= cnt_q[c];
        endcase
      end
      ovf_q <= (clr_ovf_i ? 3'b000 : ovf_q) | set_s;
    end
  end

  // FIFO storage array
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < 3; c++) begin
      if (acc_s[c]) mem_q[c][wr_ptr_q[c]] <= mcdt_data_i;
    end
  end

  // Packet FSM; outputs are loaded one beat ahead so they stay registered and hold under stall
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ch_q    <= 2'd0;
      rr_q    <= 2'd0;
      idx_q   <= 4'd0;
      for (int c = 0; c < 3; c++) seq_q[c] <= 8'd0;
      data_q  <= 32'd0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_ok_s) begin
            state_q <= HDR;
            ch_q    <= gnt_ch_s;
            data_q  <= {HDR_TAG, 6'd0, gnt_ch_s, seq_q[gnt_ch_s], 8'(PKT_LEN)};
            valid_q <= 1'b1;
            sop_q   <= 1'b1;
            eop_q   <= 1'b0;
          end
        end
        HDR: begin
          if (fmt.fmt_ready_i) begin
            state_q <= PAY;
            idx_q   <= 4'd0;
            data_q  <= mem_q[ch_q][rd_ptr_q[ch_q]];
            sop_q   <= 1'b0;
            eop_q   <= (PKT_LEN == 32'd1);
          end
        end
        PAY: begin
          if (fmt.fmt_ready_i) begin
            if (idx_q == 4'(PKT_LEN - 1)) begin
              state_q      <= IDLE;
              seq_q[ch_q]  <= seq_q[ch_q] + 8'd1;
              rr_q         <= ch_wrap({1'b0, ch_q} + 3'd1);
              data_q       <= 32'd0;
              valid_q      <= 1'b0;
              eop_q        <= 1'b0;
            end else begin
              idx_q  <= idx_q + 4'd1;
              data_q <= mem_q[ch_q][ptr_inc(rd_ptr_q[ch_q])];
              eop_q  <= ((idx_q + 4'd1) == 4'(PKT_LEN - 1));
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          sop_q   <= 1'b0;
          eop_q   <= 1'b0;
        end
      endcase
    end
  end

  assign fmt.fmt_data_o  = data_q;
  assign fmt.fmt_valid_o = valid_q;
  assign fmt.fmt_sop_o   = sop_q;
  assign fmt.fmt_eop_o   = eop_q;
  assign ovf_o           = ovf_q;

endmodule

// File: tb/tb_mcdt_pkt_formatter.sv
// Self-checking bench for mcdt_pkt_formatter: table-driven arbitration vectors,
// scoreboard of expected beats, and hand-written overflow/wrap/reset sequences.
module tb_mcdt_pkt_formatter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mdata = 32'd0;
  logic        mval = 1'b0;
  logic [1:0]  mid = 2'd0;
  logic [2:0]  ovf;
  logic        clr = 1'b0;
  logic        rdy = 1'b0;
  logic        bp_en = 1'b0;

  mcdt_pkt_formatter_if fmt_if();
  assign fmt_if.fmt_ready_i = rdy;

  mcdt_pkt_formatter dut (
    .clk_i(clk), .rst_i(rst), .mcdt_data_i(mdata), .mcdt_val_i(mval),
    .mcdt_id_i(mid), .fmt(fmt_if), .ovf_o(ovf), .clr_ovf_i(clr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic sop; logic eop; } beat_t;
  typedef struct { logic [1:0] ch; logic [31:0] base; logic [31:0] hdr; } vec_t;

  beat_t      sb[$];
  beat_t      prev;
  logic       prev_stall = 1'b0;
  logic [7:0] exp_seq [3];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Output monitor: stall stability and scoreboard compare on every accepted beat
  task automatic sample();
    beat_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (!fmt_if.fmt_valid_o || fmt_if.fmt_data_o !== prev.data ||
            fmt_if.fmt_sop_o !== prev.sop || fmt_if.fmt_eop_o !== prev.eop) begin
          bad++;
          $display("FAIL hold: got v=%b d=%h sop=%b eop=%b, required v=1 d=%h sop=%b eop=%b",
                   fmt_if.fmt_valid_o, fmt_if.fmt_data_o, fmt_if.fmt_sop_o, fmt_if.fmt_eop_o,
                   prev.data, prev.sop, prev.eop);
        end
      end
      if (fmt_if.fmt_valid_o && rdy) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got d=%h sop=%b eop=%b, required no beat",
                   fmt_if.fmt_data_o, fmt_if.fmt_sop_o, fmt_if.fmt_eop_o);
        end else begin
          e = sb.pop_front();
          if (fmt_if.fmt_data_o !== e.data || fmt_if.fmt_sop_o !== e.sop || fmt_if.fmt_eop_o !== e.eop) begin
            bad++;
            $display("FAIL beat: got d=%h sop=%b eop=%b, required d=%h sop=%b eop=%b",
                     fmt_if.fmt_data_o, fmt_if.fmt_sop_o, fmt_if.fmt_eop_o, e.data, e.sop, e.eop);
          end
        end
      end
      prev_stall = fmt_if.fmt_valid_o && !rdy;
      prev.data  = fmt_if.fmt_data_o;
      prev.sop   = fmt_if.fmt_sop_o;
      prev.eop   = fmt_if.fmt_eop_o;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (bp_en) rdy = ~rdy;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [31:0] d);
    mval = 1'b1; mid = ch; mdata = d;
    tick();
    mval = 1'b0;
  endtask

  task automatic push_words(input logic [31:0] base);
    for (int w = 0; w < 4; w++) sb.push_back('{data: base + 32'(w), sop: 1'b0, eop: (w == 3)});
  endtask

  task automatic push_pkt(input logic [1:0] ch, input logic [31:0] base);
    sb.push_back('{data: {8'hA5, 6'd0, ch, exp_seq[ch], 8'd4}, sop: 1'b1, eop: 1'b0});
    push_words(base);
    exp_seq[ch] = exp_seq[ch] + 8'd1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || fmt_if.fmt_valid_o) && n < 400) begin
      tick();
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, sb.size());
    end
  endtask

  initial begin
    vec_t tbl [6];
    int   n;
    tbl[0] = '{2'd0, 32'h00C0_0000, 32'hA500_0004};
    tbl[1] = '{2'd1, 32'h00C1_0000, 32'hA501_0004};
    tbl[2] = '{2'd2, 32'h00C2_0000, 32'hA502_0004};
    tbl[3] = '{2'd1, 32'h00C1_0010, 32'hA501_0104};
    tbl[4] = '{2'd2, 32'h00C2_0010, 32'hA502_0104};
    tbl[5] = '{2'd0, 32'h00C0_0010, 32'hA500_0104};
    for (int c = 0; c < 3; c++) exp_seq[c] = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(fmt_if.fmt_valid_o), 32'd0);
    chk("rst_data", fmt_if.fmt_data_o, 32'd0);
    chk("rst_sop_eop", {30'd0, fmt_if.fmt_sop_o, fmt_if.fmt_eop_o}, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    tick();

    // Arbitration batches: words interleaved while stalled, packets in table order
    for (int b = 0; b < 2; b++) begin
      rdy = 1'b0;
      for (int r = 0; r < 3; r++) begin
        sb.push_back('{data: tbl[b*3+r].hdr, sop: 1'b1, eop: 1'b0});
        push_words(tbl[b*3+r].base);
        exp_seq[tbl[b*3+r].ch] = exp_seq[tbl[b*3+r].ch] + 8'd1;
      end
      for (int w = 0; w < 4; w++)
        for (int r = 0; r < 3; r++) wr(tbl[b*3+r].ch, tbl[b*3+r].base + 32'(w));
      rdy = 1'b1;
      drain("arb");
    end

    // Single channel, one word every two cycles
    rdy = 1'b1;
    push_pkt(2'd0, 32'h00C0_0000);
    for (int i = 0; i < 4; i++) begin wr(2'd0, 32'h00C0_0000 + 32'(i)); tick(); end
    drain("single");
    chk("ovf_single", 32'(ovf), 32'd0);

    // Same stimulus under toggling backpressure
    push_pkt(2'd0, 32'h00C0_0000);
    bp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin wr(2'd0, 32'h00C0_0000 + 32'(i)); tick(); end
    drain("bp");
    bp_en = 1'b0;
    rdy = 1'b1;
    tick();

    // Overflow on ch1 while the output is blocked
    rdy = 1'b0;
    push_pkt(2'd1, 32'h00C1_0000);
    push_pkt(2'd1, 32'h00C1_0004);
    for (int i = 0; i < 8; i++) wr(2'd1, 32'h00C1_0000 + 32'(i));
    chk("ovf_at_full", 32'(ovf), 32'd0);
    wr(2'd1, 32'h00C1_0008);
    chk("ovf_set", 32'(ovf), 32'h2);
    mval = 1'b1; mid = 2'd1; mdata = 32'h00C1_0009; clr = 1'b1;
    tick();
    mval = 1'b0; clr = 1'b0;
    chk("ovf_set_wins", 32'(ovf), 32'h2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);
    rdy = 1'b1;
    drain("ovf");

    // Illegal id: no output, no flag, no stray FIFO contents
    for (int i = 0; i < 5; i++) wr(2'd3, 32'hDEAD_0000 + 32'(i));
    repeat (10) tick();
    chk("id3_valid", 32'(fmt_if.fmt_valid_o), 32'd0);
    chk("id3_ovf", 32'(ovf), 32'd0);
    push_pkt(2'd0, 32'h00C0_0100);
    for (int i = 0; i < 4; i++) wr(2'd0, 32'h00C0_0100 + 32'(i));
    drain("id3");

    // Sequence counter wraps through 255 -> 0 on ch2
    for (int p = 0; p < 256; p++) begin
      push_pkt(2'd2, 32'h00C2_1000 + 32'(p * 4));
      for (int i = 0; i < 4; i++) wr(2'd2, 32'h00C2_1000 + 32'(p * 4 + i));
      drain("wrap");
    end

    // Reset while a payload beat is stalled
    rdy = 1'b0;
    sb.push_back('{data: {8'hA5, 6'd0, 2'd0, exp_seq[0], 8'd4}, sop: 1'b1, eop: 1'b0});
    for (int i = 0; i < 4; i++) wr(2'd0, 32'h00C0_0200 + 32'(i));
    n = 0;
    while (!fmt_if.fmt_valid_o && n < 20) begin tick(); n++; end
    chk("mid_hdr_seen", 32'(fmt_if.fmt_valid_o), 32'd1);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    tick();
    chk("mid_pay_word", fmt_if.fmt_data_o, 32'h00C0_0200);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(fmt_if.fmt_valid_o), 32'd0);
    chk("mid_rst_data", fmt_if.fmt_data_o, 32'd0);
    chk("mid_rst_sop_eop", {30'd0, fmt_if.fmt_sop_o, fmt_if.fmt_eop_o}, 32'd0);
    sb.delete();
    for (int c = 0; c < 3; c++) exp_seq[c] = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    tick();
    push_pkt(2'd0, 32'h00C0_0300);
    for (int i = 0; i < 4; i++) wr(2'd0, 32'h00C0_0300 + 32'(i));
    drain("post_rst");
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
